// File: rtl/ptw_axi_responder.sv
// ptw_axi_responder: responder end of the TLB page-table-walk read port.
// Captures PTE read requests from the ITLB and DTLB, arbitrates between them,
// issues single-beat 64-bit AXI4 reads and returns each PTE to the requesting
// TLB as a one-cycle data-valid pulse. One walk read is in flight at a time.
// Optional feature macro: PTW_RR_ARB_EN selects round-robin tie-break; when
// undefined the DTLB always wins a tie.
module ptw_axi_responder #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  CLK,
   input  logic                  RST,
   // ITLB side
   input  logic                  I_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] I_ADDR,
   output logic                  I_DATA_VALID,
   output logic [DATA_WIDTH-1:0] I_DATA,
   output logic                  I_ERR,
   // DTLB side
   input  logic                  D_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] D_ADDR,
   output logic                  D_DATA_VALID,
   output logic [DATA_WIDTH-1:0] D_DATA,
   output logic                  D_ERR,
   // AXI4 read address channel
   output logic                  M_ARVALID,
   input  logic                  M_ARREADY,
   output logic [ADDR_WIDTH-1:0] M_ARADDR,
   output logic [7:0]            M_ARLEN,
   output logic [2:0]            M_ARSIZE,
   output logic [1:0]            M_ARBURST,
   // AXI4 read data channel
   input  logic                  M_RVALID,
   output logic                  M_RREADY,
   input  logic [DATA_WIDTH-1:0] M_RDATA,
   input  logic [1:0]            M_RRESP,
   input  logic                  M_RLAST
);

   typedef enum logic [1:0] {IDLE, AR, R} state_t;

   state_t                state;
   state_t                state_next;

   logic                  i_pend;
   logic                  d_pend;
   logic [ADDR_WIDTH-1:0] i_addr_q;
   logic [ADDR_WIDTH-1:0] d_addr_q;
   logic                  gnt_d;

   logic                  i_busy;
   logic                  d_busy;
   logic                  i_elig;
   logic                  d_elig;
   logic [ADDR_WIDTH-1:0] i_addr_eff;
   logic [ADDR_WIDTH-1:0] d_addr_eff;
   logic                  grant;
   logic                  pick_d;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_data;

`ifdef PTW_RR_ARB_EN
   logic                  last_d;
`endif

   // Single-beat reads only: RLAST carries no information, RRESP[0] does not
   // distinguish error from non-error, and PTE addresses are 8-byte aligned.
   logic                  unused;
   assign unused = ^{M_RLAST, M_RRESP[0], I_ADDR[2:0], D_ADDR[2:0]};

   // Fixed AXI attributes: one 8-byte INCR beat per walk read.
   assign M_ARLEN   = 8'd0;
   assign M_ARSIZE  = 3'd3;
   assign M_ARBURST = 2'b01;

   // Eligibility, effective addresses and tie-break for the grant taken in IDLE.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can leave it
      // unassigned and infer a latch.
      i_busy     = (state != IDLE) && !gnt_d;
      d_busy     = (state != IDLE) &&  gnt_d;
      i_elig     = i_pend | I_ADDR_VALID;
      d_elig     = d_pend | D_ADDR_VALID;
      // A fresh pulse overrides a not-yet-granted captured address.
      i_addr_eff = I_ADDR_VALID ? {I_ADDR[ADDR_WIDTH-1:3], 3'b000} : i_addr_q;
      d_addr_eff = D_ADDR_VALID ? {D_ADDR[ADDR_WIDTH-1:3], 3'b000} : d_addr_q;
      grant      = (state == IDLE) && (i_elig || d_elig);
`ifdef PTW_RR_ARB_EN
      // The port not granted most recently wins a tie.
      pick_d     = d_elig && (!i_elig || !last_d);
`else
      // DTLB has fixed priority.
      pick_d     = d_elig;
`endif
      grant_addr = pick_d ? d_addr_eff : i_addr_eff;
      rsp_err    = M_RRESP[1];
      // An errored walk returns a zero PTE (V=0) so the TLB takes a page fault.
      rsp_data   = rsp_err ? '0 : M_RDATA;
   end

   // State register.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: grant, address handshake, data handshake.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant)     state_next = AR;
         AR:      if (M_ARREADY) state_next = R;
         R:       if (M_RVALID)  state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Handshake outputs follow directly from the state.
   always_comb begin
      M_ARVALID = (state == AR);
      M_RREADY  = (state == R);
   end

   // Per-port pending flags and captured addresses; pulses on a port whose
   // read is already issued are dropped.
   always_ff @(posedge CLK) begin
      if (RST) begin
         i_pend   <= 1'b0;
         d_pend   <= 1'b0;
         i_addr_q <= '0;
         d_addr_q <= '0;
      end else begin
         if (I_ADDR_VALID && !i_busy) begin
            i_pend   <= 1'b1;
            i_addr_q <= {I_ADDR[ADDR_WIDTH-1:3], 3'b000};
         end else if (state == AR && M_ARREADY && !gnt_d) begin
            i_pend <= 1'b0;
         end
         if (D_ADDR_VALID && !d_busy) begin
            d_pend   <= 1'b1;
            d_addr_q <= {D_ADDR[ADDR_WIDTH-1:3], 3'b000};
         end else if (state == AR && M_ARREADY && gnt_d) begin
            d_pend <= 1'b0;
         end
      end
   end

   // Record the granted port and load the AR address when leaving IDLE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         gnt_d    <= 1'b0;
         M_ARADDR <= '0;
      end else if (grant) begin
         gnt_d    <= pick_d;
         M_ARADDR <= grant_addr;
      end
   end

`ifdef PTW_RR_ARB_EN
   // Remember the most recent grant; DTLB counts as most recent after reset.
   always_ff @(posedge CLK) begin
      if (RST)        last_d <= 1'b1;
      else if (grant) last_d <= pick_d;
   end
`endif

   // Route the read response to the granted port as a one-cycle pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         I_DATA_VALID <= 1'b0;
         I_DATA       <= '0;
         I_ERR        <= 1'b0;
         D_DATA_VALID <= 1'b0;
         D_DATA       <= '0;
         D_ERR        <= 1'b0;
      end else begin
         I_DATA_VALID <= 1'b0;
         I_ERR        <= 1'b0;
         D_DATA_VALID <= 1'b0;
         D_ERR        <= 1'b0;
         if (state == R && M_RVALID) begin
            if (gnt_d) begin
               D_DATA_VALID <= 1'b1;
               D_DATA       <= rsp_data;
               D_ERR        <= rsp_err;
            end else begin
               I_DATA_VALID <= 1'b1;
               I_DATA       <= rsp_data;
               I_ERR        <= rsp_err;
            end
         end
      end
   end

endmodule

// File: tb/tb_ptw_axi_responder.sv
// tb_ptw_axi_responder: directed self-checking bench for ptw_axi_responder.
// Expected order of simultaneous requests follows PTW_RR_ARB_EN.
module tb_ptw_axi_responder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        I_ADDR_VALID, D_ADDR_VALID;
   logic [63:0] I_ADDR, D_ADDR;
   logic        I_DATA_VALID, D_DATA_VALID;
   logic [63:0] I_DATA, D_DATA;
   logic        I_ERR, D_ERR;
   logic        M_ARVALID, M_ARREADY;
   logic [63:0] M_ARADDR;
   logic [7:0]  M_ARLEN;
   logic [2:0]  M_ARSIZE;
   logic [1:0]  M_ARBURST;
   logic        M_RVALID, M_RREADY;
   logic [63:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RLAST;

   int n_pass  = 0;
   int n_total = 0;

   ptw_axi_responder dut (
      .CLK(CLK), .RST(RST),
      .I_ADDR_VALID(I_ADDR_VALID), .I_ADDR(I_ADDR),
      .I_DATA_VALID(I_DATA_VALID), .I_DATA(I_DATA), .I_ERR(I_ERR),
      .D_ADDR_VALID(D_ADDR_VALID), .D_ADDR(D_ADDR),
      .D_DATA_VALID(D_DATA_VALID), .D_DATA(D_DATA), .D_ERR(D_ERR),
      .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
      .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
      .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one clock; outputs are then sampled 1ns after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Wait (bounded) for AR, check address, complete the handshake.
   task automatic ar_phase(input string tag, input logic [63:0] exp_addr);
      int n = 0;
      while (!M_ARVALID && n < 20) begin
         tick();
         n++;
      end
      check({tag, " arvalid"}, M_ARVALID, 1);
      check({tag, " araddr"}, M_ARADDR, exp_addr);
      M_ARREADY = 1'b1;
      tick();
      M_ARREADY = 1'b0;
      check({tag, " rready"}, M_RREADY, 1);
      check({tag, " arvalid low"}, M_ARVALID, 0);
   endtask

   // Return one beat and check it lands on the expected port only.
   task automatic r_phase(input string tag, input logic [63:0] rdata, input logic [1:0] resp,
                          input logic to_d, input logic [63:0] exp_data, input logic exp_err);
      M_RVALID = 1'b1;
      M_RDATA  = rdata;
      M_RRESP  = resp;
      M_RLAST  = 1'b1;
      tick();
      M_RVALID = 1'b0;
      M_RLAST  = 1'b0;
      check({tag, " d_valid"}, D_DATA_VALID, to_d);
      check({tag, " i_valid"}, I_DATA_VALID, !to_d);
      check({tag, " data"}, to_d ? D_DATA : I_DATA, exp_data);
      check({tag, " err"}, to_d ? D_ERR : I_ERR, exp_err);
      check({tag, " rready low"}, M_RREADY, 0);
   endtask

   logic        first_d;
   logic [63:0] first_addr, second_addr;

   initial begin
      RST = 1'b1;
      I_ADDR_VALID = 1'b0; I_ADDR = '0;
      D_ADDR_VALID = 1'b0; D_ADDR = '0;
      M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00; M_RLAST = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst arvalid", M_ARVALID, 0);
      check("rst rready", M_RREADY, 0);
      check("rst araddr", M_ARADDR, 0);
      check("rst i_valid", I_DATA_VALID, 0);
      check("rst d_valid", D_DATA_VALID, 0);
      check("rst i_data", I_DATA, 0);
      check("rst d_data", D_DATA, 0);
      check("rst errs", {I_ERR, D_ERR}, 0);
      RST = 1'b0;
      tick();

      // Single DTLB read with unaligned address
      D_ADDR = 64'h8000_1007; D_ADDR_VALID = 1'b1;
      tick();
      D_ADDR_VALID = 1'b0;
      check("single arvalid t+1", M_ARVALID, 1);
      check("single arlen", M_ARLEN, 0);
      check("single arsize", M_ARSIZE, 3);
      check("single arburst", M_ARBURST, 1);
      ar_phase("single", 64'h8000_1000);
      r_phase("single", 64'h0000_0000_2000_00CF, 2'b00, 1'b1, 64'h2000_00CF, 1'b0);
      tick();
      check("single pulse one cycle", D_DATA_VALID, 0);
      check("single i stays low", I_DATA_VALID, 0);

      // Simultaneous requests: order depends on arbitration mode
`ifdef PTW_RR_ARB_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      first_addr  = first_d ? 64'h2000 : 64'h1000;
      second_addr = first_d ? 64'h1000 : 64'h2000;
      I_ADDR = 64'h1000; I_ADDR_VALID = 1'b1;
      D_ADDR = 64'h2000; D_ADDR_VALID = 1'b1;
      tick();
      I_ADDR_VALID = 1'b0; D_ADDR_VALID = 1'b0;
      ar_phase("tie first", first_addr);
      r_phase("tie first", 64'h1111_0001, 2'b00, first_d, 64'h1111_0001, 1'b0);
      tick();
      check("tie second arvalid r+2", M_ARVALID, 1);
      ar_phase("tie second", second_addr);
      r_phase("tie second", 64'h2222_0002, 2'b00, !first_d, 64'h2222_0002, 1'b0);
      tick();

      // Back-pressure on both channels
      D_ADDR = 64'h5008; D_ADDR_VALID = 1'b1;
      tick();
      D_ADDR_VALID = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("bp arvalid held", M_ARVALID, 1);
         check("bp araddr held", M_ARADDR, 64'h5008);
         tick();
      end
      ar_phase("bp", 64'h5008);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("bp rready held", M_RREADY, 1);
         check("bp no data valid", {I_DATA_VALID, D_DATA_VALID}, 0);
      end
      r_phase("bp", 64'hDEAD_BEEF_0000_0003, 2'b00, 1'b1, 64'hDEAD_BEEF_0000_0003, 1'b0);
      tick();

      // Error response yields zero PTE and ERR for one cycle
      D_ADDR = 64'h6000; D_ADDR_VALID = 1'b1;
      tick();
      D_ADDR_VALID = 1'b0;
      ar_phase("err", 64'h6000);
      r_phase("err", 64'hFFFF, 2'b10, 1'b1, 64'h0, 1'b1);
      tick();
      check("err clears", D_ERR, 0);
      check("err valid clears", D_DATA_VALID, 0);

      // Overwrite of a pending, not-yet-granted DTLB address
      I_ADDR = 64'h7000; I_ADDR_VALID = 1'b1;
      tick();
      I_ADDR_VALID = 1'b0;
      D_ADDR = 64'h3000; D_ADDR_VALID = 1'b1;
      ar_phase("ovw i", 64'h7000);
      D_ADDR = 64'h4000; D_ADDR_VALID = 1'b1;
      tick();
      D_ADDR_VALID = 1'b0;
      r_phase("ovw i", 64'h7777, 2'b00, 1'b0, 64'h7777, 1'b0);
      tick();
      check("ovw d arvalid", M_ARVALID, 1);
      ar_phase("ovw d", 64'h4000);
      r_phase("ovw d", 64'h4444, 2'b00, 1'b1, 64'h4444, 1'b0);
      tick();
      tick();
      tick();
      check("ovw no stale read", M_ARVALID, 0);

      // Request arriving in the same cycle as the other port's DATA_VALID
      I_ADDR = 64'hB000; I_ADDR_VALID = 1'b1;
      tick();
      I_ADDR_VALID = 1'b0;
      ar_phase("coinc i", 64'hB000);
      r_phase("coinc i", 64'hBBBB, 2'b00, 1'b0, 64'hBBBB, 1'b0);
      D_ADDR = 64'hC000; D_ADDR_VALID = 1'b1;
      tick();
      D_ADDR_VALID = 1'b0;
      check("coinc d arvalid", M_ARVALID, 1);
      ar_phase("coinc d", 64'hC000);
      r_phase("coinc d", 64'hCCCC, 2'b00, 1'b1, 64'hCCCC, 1'b0);
      tick();

      // Reset while waiting in R abandons the read
      I_ADDR = 64'h9000; I_ADDR_VALID = 1'b1;
      tick();
      I_ADDR_VALID = 1'b0;
      ar_phase("rstR", 64'h9000);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rstR rready", M_RREADY, 0);
      check("rstR arvalid", M_ARVALID, 0);
      check("rstR araddr", M_ARADDR, 0);
      check("rstR i_data", I_DATA, 0);
      check("rstR d_data", D_DATA, 0);
      check("rstR valids", {I_DATA_VALID, D_DATA_VALID}, 0);
      tick();
      tick();
      check("rstR idle", M_ARVALID, 0);
      I_ADDR = 64'hA008; I_ADDR_VALID = 1'b1;
      tick();
      I_ADDR_VALID = 1'b0;
      check("post rst arvalid t+1", M_ARVALID, 1);
      ar_phase("post rst", 64'hA008);
      r_phase("post rst", 64'hAAAA_5555, 2'b00, 1'b0, 64'hAAAA_5555, 1'b0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ptw_axi_responder.md
# ptw_axi_responder

Responder end of the TLB page-table-walk read port. Accepts single-cycle PTE read requests from the instruction TLB and data TLB, arbitrates between them, and issues single-beat 64-bit AXI4 reads. Returns each PTE to the originating TLB as a one-cycle data-valid pulse. Sits between both TLBs and the memory-side AXI interconnect and owns all outstanding walk reads.

## Interface
Parameters:
- ADDR_WIDTH, 64, request and AXI address width
- DATA_WIDTH, 64, PTE/AXI data width; fixed at 64, other values unsupported

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- I_ADDR_VALID  in  1  ITLB request pulse (one cycle)
- I_ADDR  in  ADDR_WIDTH  ITLB PTE address
- I_DATA_VALID  out  1  ITLB response pulse
- I_DATA  out  64  PTE returned to ITLB
- I_ERR  out  1  ITLB response carried AXI error; valid with I_DATA_VALID
- D_ADDR_VALID, D_ADDR, D_DATA_VALID, D_DATA, D_ERR: same as I_* for DTLB
- M_ARVALID  out  1; M_ARREADY  in  1; M_ARADDR  out  ADDR_WIDTH
- M_ARLEN  out  8  constant 0; M_ARSIZE  out  3  constant 3; M_ARBURST  out  2  constant 1 (INCR)
- M_RVALID  in  1; M_RREADY  out  1; M_RDATA  in  64; M_RRESP  in  2; M_RLAST  in  1 (ignored, single beat)

## Operation
- Per port: pending flag plus captured address. A request pulse sets pending and captures the address with M_ARADDR[2:0] forced to 0.
- Each port has at most one walk read in flight. A pulse on a port whose pending flag is already set and not yet granted overwrites the captured address. A pulse on a port whose read is already issued is dropped.
- FSM states:
  - IDLE: if any pending flag or incoming pulse, grant one port, load M_ARADDR, set M_ARVALID, go to AR.
  - AR: hold M_ARVALID/M_ARADDR stable until M_ARREADY. On handshake, clear M_ARVALID, set M_RREADY, clear the granted port's pending flag, go to R.
  - R: on M_RVALID, clear M_RREADY, register the response to the granted port, pulse its DATA_VALID, go to IDLE.
- Tie (both requests eligible in IDLE): resolved per Configuration. The loser stays pending and is served next.
- Error (M_RRESP[1]=1): DATA forced to 0 and ERR=1. The zero PTE has V=0, so the TLB raises a page fault.
- Responses never go to the non-granted port. Both DATA_VALID outputs are never high together.
- Reset values: all DATA_VALID/ERR = 0, DATA = 0, M_ARVALID = 0, M_RREADY = 0, M_ARADDR = 0, pending flags = 0, state IDLE.
- Reset mid-transaction abandons the in-flight read. The system resets the interconnect in the same cycle.

## Timing
- Request pulse at cycle t while IDLE → M_ARVALID=1 at t+1.
- M_ARREADY at cycle a → M_RREADY=1 at a+1.
- M_RVALID with M_RREADY at cycle r → DATA_VALID pulse at r+1, exactly one cycle.
- Minimum round trip: pulse at t, DATA_VALID at t+3, with ARREADY at t+1 and RVALID at t+2.
- The FSM returns to IDLE at r+1. A pending request is granted that same cycle, so its M_ARVALID rises at r+2.
- A request pulse arriving in the same cycle as the other port's DATA_VALID is captured without loss.

## Configuration
- PTW_RR_ARB_EN defined: round-robin tie-break. The port not granted most recently wins. After reset, DTLB is treated as most recent, so ITLB wins the first tie.
- Undefined: fixed priority; DTLB always wins ties.

## Test plan
- Single DTLB read: D_ADDR=0x8000_1007 pulse → M_ARADDR=0x8000_1000, ARLEN=0, ARSIZE=3. RDATA=0x0000_0000_2000_00CF → D_DATA matches, D_DATA_VALID one cycle, I_DATA_VALID stays 0.
- Same-cycle requests I=0x1000, D=0x2000: without macro, order D then I. With PTW_RR_ARB_EN, order I then D. Both responses correct.
- Back-pressure: hold ARREADY low 5 cycles → ARADDR/ARVALID stable for all 5. Hold RVALID off 10 cycles after AR → RREADY held, no DATA_VALID.
- Error: RRESP=2'b10 with RDATA=0xFFFF → D_DATA=0, D_ERR=1 for the one DATA_VALID cycle.
- Overwrite: D pulse 0x3000 while an I read is in flight, then D pulse 0x4000 before grant → AR issued for 0x4000 only.
- Reset in R state: RST for one cycle → all outputs at reset values next cycle. A subsequent ITLB request completes normally.
